// File: rtl/inst_seq_pkg.sv
// Shared sizing, state encoding and index type for the child sequencer.
package inst_seq_pkg;
  localparam int N_CHILD = 5;
  localparam int TMO_W   = 8;
  localparam int IDX_W   = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/inst_sequencer_if.sv
// Control/child handshake bundle between a run requester and the sequencer.
interface inst_seq_if #(
  parameter int N_CHILD = inst_seq_pkg::N_CHILD,
  parameter int TMO_W   = inst_seq_pkg::TMO_W
);
  localparam int IW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

  logic               go;
  logic [N_CHILD-1:0] enable_mask;
  logic [TMO_W-1:0]   timeout;
  logic [N_CHILD-1:0] child_start;
  logic [N_CHILD-1:0] child_done;
  logic               busy;
  logic               done;
  logic [N_CHILD-1:0] err_mask;
  logic [IW-1:0]      cur_idx;

  // Requester / child side
  modport master (
    output go, enable_mask, timeout, child_done,
    input  child_start, busy, done, err_mask, cur_idx
  );

  // Sequencer side
  modport slave (
    input  go, enable_mask, timeout, child_done,
    output child_start, busy, done, err_mask, cur_idx
  );
endinterface

// File: rtl/inst_sequencer_next_set_finder.sv
// Combinational search for the lowest set mask bit strictly above idx.
module next_set_finder #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  output logic [IW-1:0] nxt,
  output logic          found
);
  // Scan downward so the last hit is the lowest qualifying bit
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        nxt   = IW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/inst_sequencer.sv
// Starts enabled children one at a time in ascending index order, waiting
// for each child's done pulse or an optional per-child timeout.
module inst_sequencer #(
  parameter int N_CHILD = inst_seq_pkg::N_CHILD,
  parameter int TMO_W   = inst_seq_pkg::TMO_W
) (
  input  logic       clk,
  input  logic       rst,
  inst_seq_if.slave  bus
);
  import inst_seq_pkg::*;

  localparam int IW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

  state_t             state_q, state_d;
  logic [N_CHILD-1:0] mask_q, mask_d;
  logic [N_CHILD-1:0] err_q, err_d;
  logic [N_CHILD-1:0] start_q, start_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IW-1:0]      low_idx, nxt_idx;
  logic               nxt_found;
  logic               adv;

  next_set_finder #(.N(N_CHILD), .IW(IW)) u_next (
    .mask  (mask_q),
    .idx   (idx_q),
    .nxt   (nxt_idx),
    .found (nxt_found)
  );

  // Lowest enabled child in the incoming request mask
  always_comb begin
    low_idx = '0;
    for (int i = N_CHILD - 1; i >= 0; i--) begin
      if (bus.enable_mask[i]) low_idx = IW'(i);
    end
  end

  // Next-state, latches, timeout counter; outputs decoded from the next state
  // so they appear registered in the same cycle the state is entered
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          err_d = '0;
          if (|bus.enable_mask) begin
            mask_d  = bus.enable_mask;
            tmo_d   = bus.timeout;
            idx_d   = low_idx;
            state_d = LAUNCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = tmo_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.child_done[idx_q]) begin
          adv = 1'b1;
        end else if ((tmo_q != '0) && (cnt_q == TMO_W'(1))) begin
          err_d[idx_q] = 1'b1;
          adv          = 1'b1;
        end else if ((tmo_q == '0) && (cnt_q <= TMO_W'(1))) begin
          // unlimited wait: park the counter so it never reaches 0
          cnt_d = TMO_W'(1);
        end else begin
          cnt_d = cnt_q - TMO_W'(1);
        end
        if (adv) begin
          if (nxt_found) begin
            idx_d   = nxt_idx;
            state_d = LAUNCH;
          end else begin
            idx_d   = '0;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == LAUNCH) ? (N_CHILD'(1) << idx_d) : '0;
    busy_d  = (state_d == LAUNCH) || (state_d == WAIT);
    done_d  = (state_d == FINISH);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.child_start = start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_mask    = err_q;
  assign bus.cur_idx     = idx_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench: each test queues expected start/done events with their
// cycle offset from the accepted go; a monitor pops and checks them.
module tb_inst_sequencer;
  import inst_seq_pkg::*;

  localparam int N = N_CHILD;

  typedef struct {
    bit is_done;
    int val;   // child index for a start, err_mask for a done
    int rel;   // cycles after the go edge
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_seq_if #(.N_CHILD(N), .TMO_W(TMO_W)) bus ();
  logic [N-1:0] resp_done;
  logic [N-1:0] inj_done;
  assign bus.child_done = resp_done | inj_done;

  inst_sequencer #(.N_CHILD(N), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   go_cyc = 0;
  int   busy_cnt = 0;
  int   dly[N];
  int   rem[N];

  always @(posedge clk) cyc <= cyc + 1;

  // Child model: pulse done dly[i] cycles after its start (dly<=0 never)
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        rem[i] = -1;
        resp_done[i] = 1'b0;
      end else begin
        resp_done[i] = (rem[i] == 0);
        if (rem[i] >= 0) rem[i] = rem[i] - 1;
        if (bus.child_start[i] && dly[i] > 0) rem[i] = dly[i] - 1;
      end
    end
  end

  // Monitor: every start or done pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.child_start != '0 || bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d start=%b done=%b", cyc, bus.child_start, bus.done);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done)
            ok = bus.done && (bus.child_start == '0) && !bus.busy && (int'(bus.err_mask) == e.val);
          else
            ok = !bus.done && bus.busy && (int'(bus.child_start) == (1 << e.val)) && (int'(bus.cur_idx) == e.val);
          ok = ok && ((cyc - go_cyc) == e.rel);
          if (!ok) begin
            errors++;
            $display("FAIL event got start=%b done=%b err=%b idx=%0d rel=%0d expected done=%0d val=%0d rel=%0d",
                     bus.child_start, bus.done, bus.err_mask, bus.cur_idx, cyc - go_cyc, e.is_done, e.val, e.rel);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push_s(input int idx, input int rel);
    exp_t e;
    e.is_done = 1'b0; e.val = idx; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input int err, input int rel);
    exp_t e;
    e.is_done = 1'b1; e.val = err; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic clr_dly();
    for (int i = 0; i < N; i++) dly[i] = -1;
  endtask

  // Called at a negedge; the go is sampled at the next posedge
  task automatic run_go(input logic [N-1:0] m, input logic [TMO_W-1:0] t);
    bus.go = 1'b1; bus.enable_mask = m; bus.timeout = t;
    go_cyc = cyc + 1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic pulse_go(input logic [N-1:0] m, input logic [TMO_W-1:0] t);
    bus.go = 1'b1; bus.enable_mask = m; bus.timeout = t;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic at_rel(input int r);
    while ((cyc - go_cyc) < r) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_start"}, int'(bus.child_start), 0);
    chk({nm, "_busy"},  int'(bus.busy), 0);
    chk({nm, "_done"},  int'(bus.done), 0);
    chk({nm, "_err"},   int'(bus.err_mask), 0);
    chk({nm, "_idx"},   int'(bus.cur_idx), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.go = 1'b0; bus.enable_mask = '0; bus.timeout = '0;
    inj_done = '0;
    clr_dly();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: mask 10101, no limit, each child done 3 cycles after start
    dly[0] = 3; dly[2] = 3; dly[4] = 3;
    push_s(0, 0); push_s(2, 4); push_s(4, 8); push_d(0, 12);
    busy_cnt = 0;
    run_go(5'b10101, 8'd0);
    drain("t1", 40);
    chk("t1_busy_cycles", busy_cnt, 12);

    // T2: mask 00110, limit 4, child 1 silent -> times out after 4 WAIT cycles
    clr_dly(); dly[2] = 2;
    push_s(1, 0); push_s(2, 5); push_d(5'b00010, 8);
    busy_cnt = 0;
    run_go(5'b00110, 8'd4);
    drain("t2", 40);
    chk("t2_busy_cycles", busy_cnt, 8);
    chk("t2_err_hold", int'(bus.err_mask), 5'b00010);

    // T3: empty mask -> done next cycle, no start, busy never high, err cleared
    push_d(0, 0);
    busy_cnt = 0;
    run_go(5'b00000, 8'd7);
    drain("t3", 10);
    chk("t3_busy_cycles", busy_cnt, 0);

    // T4: done coincides with expiry (no err); foreign done and LAUNCH-cycle done ignored
    clr_dly(); dly[0] = 3; dly[1] = 2;
    push_s(0, 0); push_s(1, 4); push_d(0, 7);
    run_go(5'b00011, 8'd3);
    at_rel(2); inj_done = 5'b00010; @(negedge clk); inj_done = '0;
    at_rel(4); inj_done = 5'b00010; @(negedge clk); inj_done = '0;
    drain("t4", 20);

    // T5: go pulses and input changes mid-run and in FINISH are ignored
    clr_dly(); dly[3] = 2; dly[4] = 2;
    push_s(3, 0); push_s(4, 3); push_d(0, 6);
    run_go(5'b11000, 8'd0);
    at_rel(1); pulse_go(5'b00001, 8'd1);
    at_rel(3); pulse_go(5'b00111, 8'd1);
    at_rel(6); pulse_go(5'b00001, 8'd1);
    drain("t5", 20);
    repeat (10) @(negedge clk);

    // T6: reset during WAIT on idx 2 aborts the run; fresh go restarts at idx 1
    clr_dly();
    push_s(1, 0); push_s(2, 3);
    run_go(5'b10110, 8'd2);
    at_rel(4);
    chk("t6_err_mid", int'(bus.err_mask), 5'b00010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("t6_after_rst");
    chk("t6_pending", exp_q.size(), 0);
    dly[1] = 2; dly[2] = 1; dly[4] = 1;
    push_s(1, 0); push_s(2, 3); push_s(4, 5); push_d(0, 7);
    run_go(5'b10110, 8'd0);
    drain("t6", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter N_CHILD, default 5: number of sequenced child instances.
REQ-002 Parameter TMO_W, default 8: timeout counter width in bits.
REQ-003 clk  input  1  single clock; every flop is rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 go  input  1  single-cycle request to start a sequence run.
REQ-006 enable_mask  input  N_CHILD  children included in the run, sampled only on an accepted go.
REQ-007 timeout  input  TMO_W  per-child wait limit in cycles; 0 means no limit; sampled only on an accepted go.
REQ-008 child_start  output  N_CHILD  one-hot, single-cycle start pulse to the current child.
REQ-009 child_done  input  N_CHILD  per-child completion pulse.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  single-cycle pulse at the end of a run.
REQ-012 err_mask  output  N_CHILD  children that timed out in the last run.
REQ-013 cur_idx  output  $clog2(N_CHILD)  index of the child being serviced; 0 when idle.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT, FINISH.
REQ-015 IDLE: go with a nonzero enable_mask SHALL latch mask and timeout, clear err_mask, set cur_idx to the lowest set mask bit, and enter LAUNCH.
REQ-016 IDLE: go with enable_mask==0 SHALL clear err_mask and enter FINISH, with no child_start issued.
REQ-017 LAUNCH lasts exactly one cycle: child_start[cur_idx]=1, load the counter with the latched timeout, then enter WAIT.
REQ-018 Latency: go sampled at edge t -> child_start high during cycle t+1.
REQ-019 WAIT, child_done[cur_idx]=1: SHALL advance.
REQ-020 WAIT, no done, limit!=0, counter==1: SHALL set err_mask[cur_idx] and advance, giving exactly `timeout` WAIT cycles.
REQ-021 WAIT otherwise: the counter decrements, saturating at 1 when the limit is 0.
REQ-022 Advance: if a higher latched mask bit exists, cur_idx takes the next higher set bit and the FSM enters LAUNCH, so the next start comes the cycle after done; otherwise enter FINISH.
REQ-023 FINISH lasts one cycle: done=1, busy=0, then IDLE.
REQ-024 busy=1 in LAUNCH and WAIT only.
REQ-025 Simultaneous done and timeout expiry: done wins and err_mask is not set.
REQ-026 go while busy or in FINISH SHALL be ignored; enable_mask and timeout changes mid-run have no effect.
REQ-027 child_done on a non-current index SHALL be ignored, including a done in the LAUNCH cycle.
REQ-028 err_mask SHALL hold its value from FINISH until the next accepted go.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and zero child_start, busy, done, err_mask, cur_idx, the counter and the latched mask/timeout.
REQ-030 Reset mid-run SHALL abort the run without a done pulse; the next cycle after rst deasserts accepts go.

Structure
REQ-031 Package inst_seq_pkg SHALL hold N_CHILD, TMO_W, the state enum and the index type.
REQ-032 One sub-module, next_set_finder, SHALL be combinational and return the lowest mask bit strictly above a given index, plus a found flag.
REQ-033 The top-level module holds the FSM, counter, latches and output registers; all outputs are registered.

Verification
REQ-034 mask=5'b10101, timeout=0, each done 3 cycles after its start -> starts on idx 0,2,4 in order, done pulse once, err_mask=0.
REQ-035 mask=5'b00110, timeout=4, child 1 never done -> exactly 4 WAIT cycles, then start[2]; after child 2 done, err_mask=5'b00010.
REQ-036 mask=0 with go -> done the next cycle, busy never high, no child_start.
REQ-037 child_done[cur] in the same cycle the counter expires -> no err bit set; child_done[other] is ignored.
REQ-038 go pulses while busy, plus mask changes mid-run -> run unaffected and a single done.
REQ-039 rst during WAIT on idx 2 -> all outputs 0 the next cycle, no done; a fresh go restarts from the lowest set bit.
